// File: rtl/axis_uart_bridge_pkg.sv
// Shared types and helpers for the AXI-Stream <-> UART bridge.
// Used by axis_uart_bridge_tx and by the baud tick generator's users.
package axis_uart_bridge_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE_ST,
    START_ST,
    DATA_ST,
    STOP_ST
  } tx_fsm;

  function automatic int clock_duration(input int freq_hz, input int uart_speed);
    return freq_hz / uart_speed;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Bit-period timer: counts 0..CLOCK_DURATION-1 while enabled and flags the last cycle.
// Shared by the UART transmit and receive paths.
module uart_baud_tick_gen #(
  parameter int CLOCK_DURATION = 868
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLOCK_DURATION);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCK_DURATION - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/axis_uart_bridge_tx.sv
// AXI-Stream slave to 8N1 UART transmitter with a one-word holding register.
// Define AXIS_UART_BRIDGE_TX_TWO_STOP_EN to send two stop bits (8N2).
module axis_uart_bridge_tx
  import axis_uart_bridge_pkg::*;
#(
  parameter int UART_SPEED = 115200,
  parameter int FREQ_HZ    = 100000000,
  parameter int N_BYTES    = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_BYTES*8-1:0]       S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  output logic                       UART_TX,
  output logic                       UART_BUSY
);

  localparam int CLOCK_DURATION = clock_duration(FREQ_HZ, UART_SPEED);
  localparam int DATA_WIDTH     = N_BYTES * UART_DATA_BITS;
  localparam int BYTE_W         = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);
`ifdef AXIS_UART_BRIDGE_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  tx_fsm                 state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tready_q, tready_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic accept, drain, baud_clear, bit_end, stop_last;

  uart_baud_tick_gen #(
    .CLOCK_DURATION(CLOCK_DURATION)
  ) u_baud (
    .clk    (clk),
    .resetn (resetn),
    .enable (state_q != IDLE_ST),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE_ST;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      stop_cnt_q   <= 1'b0;
      tready_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tready_q     <= tready_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign accept    = S_AXIS_TVALID && tready_q;
  assign stop_last = (STOP_BITS == 1) || stop_cnt_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    stop_cnt_d = stop_cnt_q;
    drain      = 1'b0;
    baud_clear = 1'b0;
    unique case (state_q)
      IDLE_ST: begin
        if (hold_valid_q) begin
          shift_d    = hold_data_q;
          drain      = 1'b1;
          baud_clear = 1'b1;
          byte_cnt_d = '0;
          state_d    = START_ST;
        end
      end
      START_ST: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = DATA_ST;
        end
      end
      DATA_ST: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = STOP_ST;
        end
      end
      STOP_ST: begin
        if (bit_end && !stop_last) begin
          stop_cnt_d = 1'b1;
        end else if (bit_end) begin
          stop_cnt_d = 1'b0;
          // After eight shifts the next byte already sits in the low bits.
          if (byte_cnt_q < LAST_BYTE) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = START_ST;
          end else if (hold_valid_q) begin
            shift_d    = hold_data_q;
            drain      = 1'b1;
            byte_cnt_d = '0;
            state_d    = START_ST;
          end else begin
            state_d = IDLE_ST;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase
    hold_valid_d = (hold_valid_q && !drain) || accept;
    hold_data_d  = accept ? S_AXIS_TDATA : hold_data_q;
  end

  // Registered outputs lag the FSM by one cycle, so every bit keeps its full period.
  always_comb begin
    tready_d = !hold_valid_d;
    busy_d   = (state_q != IDLE_ST) || hold_valid_q;
    unique case (state_q)
      IDLE_ST:  tx_d = 1'b1;
      START_ST: tx_d = 1'b0;
      DATA_ST:  tx_d = shift_q[0];
      STOP_ST:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign S_AXIS_TREADY = tready_q;
  assign UART_TX       = tx_q;
  assign UART_BUSY     = busy_q;

endmodule

// File: tb/tb_axis_uart_bridge_tx.sv
// Self-checking bench for axis_uart_bridge_tx (CLOCK_DURATION=10, N_BYTES=2).
// Honours AXIS_UART_BRIDGE_TX_TWO_STOP_EN for the stop-bit length.
module tb_axis_uart_bridge_tx;

  localparam int CD = 10;
  localparam int NB = 2;
`ifdef AXIS_UART_BRIDGE_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int BYTE_CYC = (9 + STOPS) * CD;
  localparam int WORD_CYC = NB * BYTE_CYC;

  logic        clk;
  logic        resetn;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        uartTx;
  logic        uartBusy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] expQ[$];
  int          pushed = 0;
  int          rxWords = 0;

  // Frame bits per word: index 0 is the first line level after the start edge.
  typedef struct {
    logic [15:0] word;
    logic [19:0] frames;
  } vec_t;
  vec_t vecs[4];

  axis_uart_bridge_tx #(
    .UART_SPEED(100000),
    .FREQ_HZ   (1000000),
    .N_BYTES   (NB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .S_AXIS_TDATA (tdata),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .UART_TX      (uartTx),
    .UART_BUSY    (uartBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic expBit(input logic [39:0] pat, input int k);
    int b = k / BYTE_CYC;
    int w = (k % BYTE_CYC) / CD;
    if (w > 9) return 1'b1;
    return pat[b*10 + w];
  endfunction

  // Independent line receiver: samples mid-bit and rebuilds words byte 0 first.
  int          dCnt, dN, dByteIdx;
  bit          dActive;
  logic [7:0]  dByte;
  logic [15:0] dWord;
  always @(negedge clk) begin
    if (!resetn) begin
      dActive  = 1'b0;
      dByteIdx = 0;
    end else if (!dActive) begin
      if (uartTx == 1'b0) begin
        dActive = 1'b1;
        dCnt    = 0;
      end
    end else begin
      dCnt++;
      if (dCnt >= CD/2 && ((dCnt - CD/2) % CD) == 0) begin
        dN = (dCnt - CD/2) / CD;
        if (dN == 0) begin
          checkEq("rxStartBit", uartTx, 0);
        end else if (dN <= 8) begin
          dByte[dN-1] = uartTx;
        end else begin
          checkEq("rxStopBit", uartTx, 1);
          if (dN == 8 + STOPS) begin
            dActive = 1'b0;
            dWord[dByteIdx*8 +: 8] = dByte;
            dByteIdx++;
            if (dByteIdx == NB) begin
              dByteIdx = 0;
              rxWords++;
              if (expQ.size() == 0) checkEq("rxUnexpectedWord", dWord, 32'hFFFF_FFFF);
              else checkEq("rxWord", dWord, expQ.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] w, output bit ok);
    ok     = 1'b0;
    tdata  = w;
    tvalid = 1'b1;
    for (int i = 0; i < 4 * WORD_CYC; i++) begin
      if (tready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkEq("acceptTimeout", 0, 1);
  endtask

  task automatic checkOutput(input logic [39:0] pat, input int nWords, input string name);
    int badTx = 0;
    int badBusy = 0;
    for (int k = 0; k < nWords * WORD_CYC; k++) begin
      @(negedge clk);
      if (uartTx !== expBit(pat, k)) badTx++;
      if (uartBusy !== 1'b1) badBusy++;
    end
    checkEq({name, "_lineBadCycles"}, badTx, 0);
    checkEq({name, "_busyBadCycles"}, badBusy, 0);
  endtask

  task automatic waitIdle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 4 * WORD_CYC; i++) begin
      @(negedge clk);
      if (!uartBusy) begin
        idle = 1'b1;
        break;
      end
    end
    checkEq({name, "_idleReached"}, idle, 1);
  endtask

  task automatic sendAndCheck(input vec_t v, input string name);
    bit ok;
    expQ.push_back(v.word);
    pushed++;
    applyStimulus(v.word, ok);
    if (!ok) begin
      void'(expQ.pop_back());
      pushed--;
      return;
    end
    @(negedge clk);
    tvalid = 1'b0;
    checkEq({name, "_treadyAfterAccept"}, tready, 0);
    checkEq({name, "_txBeforeStart"}, uartTx, 1);
    @(negedge clk);
    checkEq({name, "_treadyAfterDrain"}, tready, 1);
    checkEq({name, "_txStillIdle"}, uartTx, 1);
    checkEq({name, "_busyRise"}, uartBusy, 1);
    checkOutput({20'h0, v.frames}, 1, name);
    @(negedge clk);
    checkEq({name, "_busyFall"}, uartBusy, 0);
    checkEq({name, "_txIdleAfter"}, uartTx, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int j;
    int bad;
    vecs[0] = '{16'hA55A, 20'hD2AB4};
    vecs[1] = '{16'h00FF, 20'h803FE};
    vecs[2] = '{16'h1234, 20'h89268};
    vecs[3] = '{16'hABCD, 20'hD5B9A};

    resetn = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0 || i == 4) begin
        checkEq("rst_tx", uartTx, 1);
        checkEq("rst_tready", tready, 0);
        checkEq("rst_busy", uartBusy, 0);
      end
    end
    #2 resetn = 1'b1;
    @(negedge clk);
    checkEq("rel_tready", tready, 1);

    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tdata = 16'($urandom);
      @(negedge clk);
      if (uartBusy !== 1'b0 || uartTx !== 1'b1) bad++;
    end
    checkEq("noValidIgnored", bad, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) begin
      sendAndCheck(vecs[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    $display("[TB] back-to-back words");
    expQ.push_back(16'h1234);
    expQ.push_back(16'hABCD);
    pushed += 2;
    applyStimulus(16'h1234, ok);
    @(negedge clk);
    tdata = 16'hABCD;
    checkEq("b2b_treadyN0", tready, 0);
    @(negedge clk);
    checkEq("b2b_treadyN1", tready, 1);
    fork
      checkOutput({vecs[3].frames, vecs[2].frames}, 2, "b2b");
      begin
        @(negedge clk);
        tvalid = 1'b0;
        checkEq("b2b_treadyAfterSecond", tready, 0);
        j = -1;
        for (int n = 3; n < 3 * WORD_CYC; n++) begin
          @(negedge clk);
          if (tready) begin
            j = n;
            break;
          end
        end
        checkEq("b2b_holdDrainCycle", j, 1 + WORD_CYC);
      end
    join
    @(negedge clk);
    checkEq("b2b_busyFall", uartBusy, 0);

    $display("[TB] random loopback");
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      tvalid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        tdata = 16'($urandom);
        @(negedge clk);
      end
      w = 16'($urandom);
      expQ.push_back(w);
      pushed++;
      applyStimulus(w, ok);
      @(negedge clk);
      tvalid = 1'b0;
    end
    waitIdle("rand");
    repeat (2) @(negedge clk);
    checkEq("rand_queueDrained", expQ.size(), 0);
    checkEq("rand_rxCount", rxWords, pushed);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h0000, ok);
    @(negedge clk);
    tdata = 16'h5555;
    @(negedge clk);
    checkEq("midrst_treadyForSecond", tready, 1);
    @(negedge clk);
    tvalid = 1'b0;
    for (int n = 3; n <= 47; n++) @(negedge clk);
    checkEq("midrst_txLowBeforeReset", uartTx, 0);
    #2 resetn = 1'b0;
    #1;
    checkEq("midrst_txAsync", uartTx, 1);
    checkEq("midrst_busyAsync", uartBusy, 0);
    checkEq("midrst_treadyAsync", tready, 0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uartTx !== 1'b1 || uartBusy !== 1'b0) bad++;
    end
    checkEq("midrst_pendingDiscarded", bad, 0);
    checkEq("midrst_treadyBack", tready, 1);
    sendAndCheck(vecs[1], "afterRst");
    repeat (2) @(negedge clk);
    checkEq("final_queueDrained", expQ.size(), 0);
    checkEq("final_rxCount", rxWords, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
